// File: rtl/uart_echo_bridge_pkg.sv
// Shared types and constants for the UART echo/host bridge.
// Holds the drain FSM encoding, the mode encoding and the drop-counter helper.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    SEND,
    WAIT_HI,
    WAIT_LO
  } drain_state_t;

  localparam logic MODE_ECHO  = 1'b0;
  localparam logic MODE_HOST  = 1'b1;
  localparam int   DROP_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/uart_echo_bridge_if.sv
// Host stream port of the bridge: byte stream into the TX FIFO and
// the one-entry register carrying received bytes back to the host.
interface uart_echo_bridge_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/uart_echo_bridge_sync_fifo.sv
// Single-clock FIFO with an array store and a registered read port.
// The read register only changes on a pop, so it doubles as a stable output.
module bridge_sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_out,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_cnt_q;
  logic [ADDR_W:0]   rd_cnt_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              wr_ok;
  logic              rd_ok;

  // Counters carry one extra bit so full and empty stay distinguishable.
  assign level = wr_cnt_q - rd_cnt_q;
  assign full  = (level == (ADDR_W+1)'(DEPTH));
  assign empty = (level == '0);
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_ff @(posedge clk_out) begin
    if (wr_ok) begin
      mem_q[wr_cnt_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk_out) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_ok) begin
        wr_cnt_q <= wr_cnt_q + (ADDR_W+1)'(1);
      end
      if (rd_ok) begin
        rd_data_q <= mem_q[rd_cnt_q[ADDR_W-1:0]];
        rd_cnt_q  <= rd_cnt_q + (ADDR_W+1)'(1);
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_echo_bridge.sv
// Byte-buffer controller between the UART core and either a loopback (ECHO)
// or a host stream (HOST); one tx_send per byte, handshaked on tx_busy.
module uart_echo_bridge
  import uart_bridge_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int DEPTH   = 16,
  parameter  int BUSY_TO = 4,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                  clk_out,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_valid,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_send,
  input  logic                  tx_busy,
  uart_echo_bridge_if.slave     host,
  output logic [ADDR_W:0]       level,
  output logic                  full,
  output logic                  empty,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int CNT_W = $clog2(BUSY_TO + 1);

  drain_state_t          state_q;
  logic                  tx_send_q;
  logic [CNT_W-1:0]      busy_cnt_q;
  logic                  mode_q,      mode_d;
  logic [DATA_W-1:0]     out_data_q,  out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q,  drop_cnt_d;

  logic                  fifo_wr;
  logic [DATA_W-1:0]     fifo_wr_data;
  logic                  fifo_rd;
  logic                  fifo_full;
  logic                  fifo_empty;

  // The FIFO's read register is the tx_data holding register.
  bridge_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_out (clk_out),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wr_data),
    .rd_en   (fifo_rd),
    .rd_data (tx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign fifo_rd       = (state_q == POP);
  assign host.in_ready = (mode_q == MODE_HOST) & ~fifo_full;

  always_comb begin
    fifo_wr      = 1'b0;
    fifo_wr_data = rx_data;
    if (mode_q == MODE_HOST) begin
      fifo_wr      = host.in_valid & host.in_ready;
      fifo_wr_data = host.in_data;
    end else begin
      fifo_wr      = rx_valid & ~fifo_full;
    end
  end

  // Mode only changes between byte streams: drain idle and nothing queued.
  always_comb begin
    mode_d      = ((state_q == IDLE) && fifo_empty) ? mode : mode_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    drop_cnt_d  = drop_cnt_q;
    if (out_valid_q && host.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (rx_valid) begin
      if (mode_q == MODE_ECHO) begin
        if (fifo_full) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
        end
      end else if (out_valid_q && !host.out_ready) begin
        drop_cnt_d = sat_inc(drop_cnt_q);
      end else begin
        out_data_d  = rx_data;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_out) begin
    if (rst) begin
      mode_q      <= MODE_ECHO;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Drain FSM; the busy timeout counts from the SEND cycle.
  always_ff @(posedge clk_out) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_send_q  <= 1'b0;
      busy_cnt_q <= '0;
    end else begin
      tx_send_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty && !tx_busy) begin
            state_q <= POP;
          end
        end
        POP: begin
          state_q   <= SEND;
          tx_send_q <= 1'b1;
        end
        SEND: begin
          state_q    <= WAIT_HI;
          busy_cnt_q <= CNT_W'(1);
        end
        WAIT_HI: begin
          if (tx_busy || (busy_cnt_q >= CNT_W'(BUSY_TO - 1))) begin
            state_q <= WAIT_LO;
          end else begin
            busy_cnt_q <= busy_cnt_q + CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_send        = tx_send_q;
  assign host.out_data  = out_data_q;
  assign host.out_valid = out_valid_q;
  assign full           = fifo_full;
  assign empty          = fifo_empty;
  assign drop_cnt       = drop_cnt_q;

endmodule
